// File: rtl/iter_counter_pkg.sv
// Shared definitions for the iteration counter and the multi-cycle datapath
// controls (multiplier, divider) that it sequences.
package iter_counter_pkg;

    // Controller state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } iter_state_e;

    // Default iteration count, shared by the multiplier and divider controls
    localparam int unsigned DEFAULT_ITERS = 32;

endpackage : iter_counter_pkg

// File: rtl/iter_counter.sv
// Parametrised iteration counter: Load starts a run of last+1 counted steps,
// Busy covers the run, K pulses for one cycle after the final step.
// Supports a programmable terminal count, a step enable (stall), Abort, and an
// exposed count value.
// Optional build macro ITER_COUNTER_DOWN_EN: Count loads with last and counts
// down to 0, so it shows the steps remaining; timing is unchanged.
module iter_counter
    import iter_counter_pkg::*;
#(
    parameter int unsigned WIDTH        = 5,
    parameter int unsigned DEFAULT_LAST = DEFAULT_ITERS - 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Load,
    input  logic             UseTc,
    input  logic [WIDTH-1:0] TcIn,
    input  logic             Enable,
    input  logic             Abort,
    output logic [WIDTH-1:0] Count,
    output logic             Busy,
    output logic             K
);

    localparam logic [WIDTH-1:0] DEF_LAST = WIDTH'(DEFAULT_LAST);

    iter_state_e      state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] last_q,  last_d;
    logic             busy_q,  busy_d;
    logic             k_q,     k_d;

    logic [WIDTH-1:0] load_last_c;
    logic [WIDTH-1:0] load_count_c;
    logic [WIDTH-1:0] step_count_c;
    logic             final_step_c;

    // Terminal index selected at Load
    assign load_last_c = UseTc ? TcIn : DEF_LAST;

`ifdef ITER_COUNTER_DOWN_EN
    // Down mode: Count shows remaining steps and terminates at zero
    assign load_count_c = load_last_c;
    assign step_count_c = count_q - WIDTH'(1);
    assign final_step_c = (count_q == '0);
`else
    // Up mode: Count shows the current step index and terminates at last
    assign load_count_c = '0;
    assign step_count_c = count_q + WIDTH'(1);
    assign final_step_c = (count_q == last_q);
`endif

    // Next-state and next-output logic; priority Load > Abort > Enable
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        last_d  = last_q;

        if (Load) begin
            state_d = RUN;
            count_d = load_count_c;
            last_d  = load_last_c;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (Abort) begin
                        state_d = IDLE;
                    end else if (Enable) begin
                        if (final_step_c) begin
                            state_d = DONE;
                        end else begin
                            count_d = step_count_c;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d == RUN);
        k_d    = (state_d == DONE);
    end

    // State, count, terminal and output registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= IDLE;
            count_q <= '0;
            last_q  <= DEF_LAST;
            busy_q  <= 1'b0;
            k_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            k_q     <= k_d;
        end
    end

    assign Count = count_q;
    assign Busy  = busy_q;
    assign K     = k_q;

endmodule : iter_counter

// File: tb/tb_iter_counter.sv
// Directed self-checking bench for iter_counter (default parameters).
// Expected counts follow ITER_COUNTER_DOWN_EN when the bench is built with it.
module tb_iter_counter;

    localparam int unsigned W = 5;

    logic         Clk;
    logic         Rst;
    logic         Load;
    logic         UseTc;
    logic [W-1:0] TcIn;
    logic         Enable;
    logic         Abort;
    logic [W-1:0] Count;
    logic         Busy;
    logic         K;

    int unsigned n_checks;
    int unsigned n_errors;

    iter_counter dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Load   (Load),
        .UseTc  (UseTc),
        .TcIn   (TcIn),
        .Enable (Enable),
        .Abort  (Abort),
        .Count  (Count),
        .Busy   (Busy),
        .K      (K)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Expected Count after idx enabled steps of a run whose last index is last
    function automatic logic [W-1:0] exp_cnt(input int unsigned idx, input int unsigned last);
`ifdef ITER_COUNTER_DOWN_EN
        exp_cnt = W'(last - idx);
`else
        exp_cnt = W'(idx + 0 * last);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One active edge, then settle on the falling edge for sampling/driving
    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic expect_out(input string tag, input logic [W-1:0] c, input logic b, input logic k);
        check({tag, ".count"}, 32'(Count), 32'(c));
        check({tag, ".busy"},  32'(Busy),  32'(b));
        check({tag, ".k"},     32'(K),     32'(k));
    endtask

    task automatic do_load(input logic use_tc, input logic [W-1:0] tc);
        Load  = 1'b1;
        UseTc = use_tc;
        TcIn  = tc;
        step();
        Load  = 1'b0;
    endtask

    initial begin
        int unsigned k_seen;
        logic [W-1:0] hold_cnt;
        int unsigned pat_en [6];
        int unsigned pat_idx[6];

        n_checks = 0;
        n_errors = 0;
        Rst = 1'b0; Load = 1'b1; UseTc = 1'b1; TcIn = W'(3);
        Enable = 1'b1; Abort = 1'b0;

        // Reset dominates Load
        @(negedge Clk);
        for (int i = 0; i < 2; i++) begin
            step();
            expect_out("reset", '0, 1'b0, 1'b0);
        end

        // Default terminal count: 32 enabled steps
        Rst = 1'b1;
        do_load(1'b0, W'(3));
        expect_out("def_load", exp_cnt(0, 31), 1'b1, 1'b0);
        for (int i = 1; i < 32; i++) begin
            step();
            expect_out("def_run", exp_cnt(i, 31), 1'b1, 1'b0);
        end
        step();
        expect_out("def_done", exp_cnt(31, 31), 1'b0, 1'b1);
        step();
        expect_out("def_idle", exp_cnt(31, 31), 1'b0, 1'b0);

        // Stalls: TcIn=3 with Enable 1,0,1,1,0,1
        pat_en  = '{1, 0, 1, 1, 0, 1};
        pat_idx = '{1, 1, 2, 3, 3, 3};
        Enable = 1'b1;
        do_load(1'b1, W'(3));
        expect_out("stall_load", exp_cnt(0, 3), 1'b1, 1'b0);
        k_seen = 0;
        for (int i = 0; i < 6; i++) begin
            Enable = pat_en[i][0];
            step();
            check("stall_cnt", 32'(Count), 32'(exp_cnt(pat_idx[i], 3)));
            check("stall_busy", 32'(Busy), 32'(i != 5));
            k_seen += 32'(K);
        end
        check("stall_k_last", 32'(K), 32'd1);
        Enable = 1'b1;
        step();
        k_seen += 32'(K);
        check("stall_k_once", k_seen, 32'd1);
        expect_out("stall_idle", exp_cnt(3, 3), 1'b0, 1'b0);

        // Abort at step 4 of TcIn=7: Count holds, no K
        do_load(1'b1, W'(7));
        for (int i = 0; i < 4; i++) step();
        check("abort_pre", 32'(Count), 32'(exp_cnt(4, 7)));
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        expect_out("abort", exp_cnt(4, 7), 1'b0, 1'b0);
        k_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            k_seen += 32'(K);
        end
        check("abort_no_k", k_seen, 32'd0);
        check("abort_hold", 32'(Count), 32'(exp_cnt(4, 7)));

        // Restart mid-run: TcIn=5, reload TcIn=2 at step 3
        do_load(1'b1, W'(5));
        for (int i = 0; i < 3; i++) step();
        check("restart_pre", 32'(Count), 32'(exp_cnt(3, 5)));
        do_load(1'b1, W'(2));
        expect_out("restart_load", exp_cnt(0, 2), 1'b1, 1'b0);
        step();
        expect_out("restart_s1", exp_cnt(1, 2), 1'b1, 1'b0);
        step();
        expect_out("restart_s2", exp_cnt(2, 2), 1'b1, 1'b0);
        step();
        expect_out("restart_done", exp_cnt(2, 2), 1'b0, 1'b1);
        step();

        // last=0, reloaded on the K cycle
        do_load(1'b1, W'(0));
        expect_out("z_load", '0, 1'b1, 1'b0);
        step();
        expect_out("z_done1", '0, 1'b0, 1'b1);
        do_load(1'b1, W'(0));
        expect_out("z_reload", '0, 1'b1, 1'b0);
        step();
        expect_out("z_done2", '0, 1'b0, 1'b1);
        step();
        expect_out("z_idle", '0, 1'b0, 1'b0);

        // Load and Abort together: Load wins
        Abort = 1'b1;
        do_load(1'b1, W'(1));
        Abort = 1'b0;
        expect_out("la_load", exp_cnt(0, 1), 1'b1, 1'b0);
        step();
        check("la_step", 32'(Count), 32'(exp_cnt(1, 1)));
        // Abort together with the final enabled step: Abort wins, no K
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        expect_out("abort_final", exp_cnt(1, 1), 1'b0, 1'b0);
        step();
        check("abort_final_k", 32'(K), 32'd0);

        // Idle ignores Enable and Abort
        hold_cnt = Count;
        Enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Abort = i[0];
            step();
        end
        Abort = 1'b0;
        expect_out("idle_hold", hold_cnt, 1'b0, 1'b0);

        // Reset while running clears everything
        do_load(1'b1, W'(9));
        step();
        Rst = 1'b0;
        step();
        Rst = 1'b1;
        expect_out("reset_run", '0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_iter_counter
